// File: rtl/fwd_source_stage.sv
// fwd_source_stage: single-entry pipeline register at the producer end of the
// operand-forwarding path. Holds one in-flight instruction's destination and
// result, and tells the decode-side selector whether that result can be
// forwarded yet (fwd_stall while a load-type result is still outstanding).
//
// state   | meaning
// --------+---------------------------------------------------------------
// EMPTY   | no entry held, stage can accept
// PENDING | entry held, result still owed on the response port
// READY   | entry held with its result, offered downstream
// DRAIN   | entry was flushed while its response was owed; swallow it
module fwd_source_stage #(
  parameter int XLEN           = 32,
  parameter bit FWD_RSP_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wb_en,
  input  logic [4:0]      in_wb_reg,
  input  logic            in_result_valid,
  input  logic [XLEN-1:0] in_result,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_wb_en,
  output logic [4:0]      out_wb_reg,
  output logic [XLEN-1:0] out_data,
  output logic            fwd_valid,
  output logic            fwd_stall,
  output logic [4:0]      fwd_wb_reg,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_READY   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              accept;
  logic              bypass_hit;

  // PENDING and DRAIN never accept so an owed response can never be lost;
  // reset also holds the stage closed.
  assign in_ready   = reset_n & ~flush &
                      ((state_q == ST_EMPTY) | ((state_q == ST_READY) & out_ready));
  assign accept     = in_valid & in_ready;
  assign bypass_hit = FWD_RSP_BYPASS & (state_q == ST_PENDING) & rsp_valid;

  // State and held-entry registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_EMPTY;
      wb_en_q  <= 1'b0;
      wb_reg_q <= 5'd0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wb_en_q  <= wb_en_d;
      wb_reg_q <= wb_reg_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic; a same-cycle accept (EMPTY, or READY draining) overrides
  // the vacate decision so back-to-back instructions see no bubble.
  always_comb begin
    state_d  = state_q;
    wb_en_d  = wb_en_q;
    wb_reg_d = wb_reg_q;
    data_d   = data_q;
    case (state_q)
      ST_EMPTY: ;
      ST_PENDING: begin
        if (flush) begin
          state_d = rsp_valid ? ST_EMPTY : ST_DRAIN;
        end else if (rsp_valid) begin
          state_d = ST_READY;
          data_d  = rsp_data;
        end
      end
      ST_READY: begin
        if (flush || out_ready) state_d = ST_EMPTY;
      end
      ST_DRAIN: begin
        if (rsp_valid) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      state_d  = in_result_valid ? ST_READY : ST_PENDING;
      wb_en_d  = in_wb_en;
      wb_reg_d = in_wb_reg;
      data_d   = in_result;
    end
  end

  // Downstream outputs come straight from registers (no out_ready -> out_* path).
  always_comb begin
    out_valid  = (state_q == ST_READY);
    out_wb_en  = wb_en_q;
    out_wb_reg = wb_reg_q;
    out_data   = data_q;
  end

  // Forwarding view; x0 is deliberately not masked here, the consumer does it.
  always_comb begin
    fwd_valid  = ((state_q == ST_PENDING) | (state_q == ST_READY)) & wb_en_q;
    fwd_stall  = (state_q == ST_PENDING) & ~bypass_hit;
    fwd_wb_reg = wb_reg_q;
    fwd_data   = bypass_hit ? rsp_data : data_q;
  end

`ifndef SYNTHESIS
  // A response is only legal while one is owed (PENDING or DRAIN).
  rsp_only_when_owed: assert property (
    @(posedge clk) disable iff (!reset_n)
    rsp_valid |-> (state_q == ST_PENDING || state_q == ST_DRAIN)
  ) else $error("rsp_valid while no response is outstanding");
`endif

endmodule

// File: tb/tb_fwd_source_stage.sv
// Bench for fwd_source_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fwd_source_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wb_en = 1'b0;
  logic [4:0]  in_wb_reg = 5'd0;
  logic        in_result_valid = 1'b0;
  logic [31:0] in_result = 32'd0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_wb_en;
  logic [4:0]  out_wb_reg;
  logic [31:0] out_data;
  logic        fwd_valid;
  logic        fwd_stall;
  logic [4:0]  fwd_wb_reg;
  logic [31:0] fwd_data;

  int n_pass = 0;
  int n_total = 0;

  fwd_source_stage #(.XLEN(32), .FWD_RSP_BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
    .in_wb_reg(in_wb_reg), .in_result_valid(in_result_valid), .in_result(in_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
    .out_wb_reg(out_wb_reg), .out_data(out_data),
    .fwd_valid(fwd_valid), .fwd_stall(fwd_stall), .fwd_wb_reg(fwd_wb_reg),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: at most one instruction held (m_occ), whether its result is known
  // yet (m_have), and how many responses are still owed to a killed entry.
  bit          m_occ = 0;
  bit          m_have = 0;
  bit          m_wb_en = 0;
  logic [4:0]  m_reg = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          m_orphans = 0;

  function automatic bit m_pending(); return m_occ && !m_have; endfunction
  function automatic bit m_ready();   return m_occ && m_have;  endfunction
  function automatic bit m_owed();    return m_pending() || (m_orphans > 0); endfunction
  function automatic bit m_in_ready();
    return reset_n && !flush && ((!m_occ && m_orphans == 0) || (m_ready() && out_ready));
  endfunction

  task automatic m_clear();
    m_occ = 0; m_have = 0; m_wb_en = 0; m_reg = 0; m_data = 0; m_orphans = 0;
  endtask

  always @(negedge reset_n) m_clear();

  always @(posedge clk) begin : model_step
    bit acc;
    if (!reset_n) begin
      m_clear();
    end else begin
      acc = m_in_ready() && in_valid;
      if (m_orphans > 0) begin
        if (rsp_valid) m_orphans = 0;
      end else if (m_pending()) begin
        if (flush) begin
          m_occ = 0;
          if (!rsp_valid) m_orphans = 1;
        end else if (rsp_valid) begin
          m_have = 1;
          m_data = rsp_data;
        end
      end else if (m_ready()) begin
        if (flush || out_ready) m_occ = 0;
      end
      if (acc) begin
        m_occ   = 1;
        m_have  = in_result_valid;
        m_wb_en = in_wb_en;
        m_reg   = in_wb_reg;
        m_data  = in_result;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin : cmp
    bit e_fv, e_stall;
    e_fv    = m_occ && m_wb_en;
    e_stall = m_pending() && !rsp_valid;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ready()});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_fv});
    chk("fwd_stall", {31'd0, fwd_stall}, {31'd0, e_stall});
    if (m_ready()) begin
      chk("out_wb_en", {31'd0, out_wb_en}, {31'd0, m_wb_en});
      chk("out_wb_reg", {27'd0, out_wb_reg}, {27'd0, m_reg});
      chk("out_data", out_data, m_data);
    end
    if (e_fv) chk("fwd_wb_reg", {27'd0, fwd_wb_reg}, {27'd0, m_reg});
    if (m_occ && !e_stall) chk("fwd_data", fwd_data, m_pending() ? rsp_data : m_data);
  end

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // ALU entry
    in_valid = 1; in_wb_en = 1; in_result_valid = 1; in_wb_reg = 5; in_result = 32'h1234;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("alu_fwd_stall", {31'd0, fwd_stall}, 32'd0);
    chk("alu_fwd_wb_reg", {27'd0, fwd_wb_reg}, 32'd5);
    chk("alu_fwd_data", fwd_data, 32'h1234);
    chk("alu_out_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1;
    #1 chk("alu_in_ready_drain", {31'd0, in_ready}, 32'd1);
    tick();
    out_ready = 0;
    @(negedge clk);
    chk("alu_empty_fwd", {31'd0, fwd_valid}, 32'd0);
    chk("alu_empty_out", {31'd0, out_valid}, 32'd0);
    tick();

    // Load entry with bypassed response
    in_valid = 1; in_result_valid = 0; in_wb_reg = 7; in_result = 32'h5555;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld_stall", {31'd0, fwd_stall}, 32'd1);
      tick();
    end
    rsp_valid = 1; rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_bypass_stall", {31'd0, fwd_stall}, 32'd0);
    chk("ld_bypass_data", fwd_data, 32'hDEADBEEF);
    tick();
    rsp_valid = 0;
    @(negedge clk);
    chk("ld_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_out_data", out_data, 32'hDEADBEEF);

    // Back-to-back reload
    out_ready = 1; in_valid = 1; in_result_valid = 1; in_wb_reg = 3; in_result = 32'd9;
    #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_out_wb_reg", {27'd0, out_wb_reg}, 32'd3);
    chk("b2b_out_data", out_data, 32'd9);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Flush while PENDING, no response -> DRAIN
    in_valid = 1; in_result_valid = 0; in_wb_reg = 4;
    tick();
    in_valid = 0; flush = 1;
    tick();
    flush = 0; rsp_valid = 1; rsp_data = 32'hBAD0BAD0;
    @(negedge clk);
    chk("drain_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rsp_valid = 0;
    @(negedge clk);
    chk("drain_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("drain_data_hidden", {31'd0, out_data != 32'hBAD0BAD0}, 32'd1);
    tick();

    // Flush + response in same PENDING cycle
    in_valid = 1; in_result_valid = 0; in_wb_reg = 8;
    tick();
    in_valid = 0; flush = 1; rsp_valid = 1; rsp_data = 32'h0F0F0F0F;
    tick();
    flush = 0; rsp_valid = 0;
    @(negedge clk);
    chk("flush_rsp_empty", {31'd0, in_ready}, 32'd1);
    chk("flush_rsp_out", {31'd0, out_valid}, 32'd0);

    // Flush + in_valid in EMPTY
    in_valid = 1; flush = 1; in_result_valid = 1; in_wb_reg = 9; in_result = 32'h77;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_no_capture_fwd", {31'd0, fwd_valid}, 32'd0);
    chk("flush_no_capture_out", {31'd0, out_valid}, 32'd0);
    tick();

    // Non-writing instruction
    in_valid = 1; in_wb_en = 0; in_result_valid = 1; in_wb_reg = 2; in_result = 32'h42;
    @(negedge clk);
    chk("nowb_fwd_empty", {31'd0, fwd_valid}, 32'd0);
    tick();
    in_valid = 0; in_wb_en = 1;
    @(negedge clk);
    chk("nowb_out_valid", {31'd0, out_valid}, 32'd1);
    chk("nowb_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("nowb_out_wb_en", {31'd0, out_wb_en}, 32'd0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Reset mid-PENDING
    in_valid = 1; in_result_valid = 0; in_wb_reg = 6; in_result = 32'h99;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("rst_pend_stall", {31'd0, fwd_stall}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_mid_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_mid_fwd_stall", {31'd0, fwd_stall}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mid_wb_reg", {27'd0, fwd_wb_reg}, 32'd0);
    chk("rst_mid_out_data", out_data, 32'd0);
    tick();
    reset_n = 1;
    tick();

    // Randomized traffic; responses only when the model says one is owed
    for (int c = 0; c < 4000; c++) begin
      in_valid        = 1'($urandom_range(0, 1));
      in_wb_en        = ($urandom_range(0, 3) != 0);
      in_wb_reg       = 5'($urandom);
      in_result_valid = 1'($urandom_range(0, 1));
      in_result       = $urandom;
      out_ready       = 1'($urandom_range(0, 1));
      flush           = ($urandom_range(0, 15) == 0);
      rsp_data        = $urandom;
      rsp_valid       = m_owed() && ($urandom_range(0, 2) == 0);
      tick();
    end
    in_valid = 0; flush = 0; rsp_valid = 0; out_ready = 0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fwd_source_stage.md
Name: fwd_source_stage

Overview:
- Producer end of the operand-forwarding interface: a single-entry pipeline stage register that holds one in-flight instruction's destination register and result.
- Drives fwd_valid / fwd_stall / fwd_wb_reg / fwd_data to the decode-side forwarding selector.
- The result is either available at entry (ALU-type) or arrives later on a response port (load-type); until it arrives the stage reports a stall-forward.
- Instantiated for the execute, memory0 and memory1 positions.

Parameters:
- XLEN, 32, data width of results and forwarded data.
- FWD_RSP_BYPASS, 1, when 1, response data is forwarded combinationally in its arrival cycle.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_wb_en  input  1  instruction writes a register
- in_wb_reg  input  5  destination register
- in_result_valid  input  1  result available at entry
- in_result  input  XLEN  result when in_result_valid
- rsp_valid  input  1  late result (e.g. load data) valid
- rsp_data  input  XLEN  late result
- flush  input  1  kill held entry, block acceptance
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream accepts
- out_wb_en  output  1  held wb_en
- out_wb_reg  output  5  held destination
- out_data  output  XLEN  held result
- fwd_valid  output  1  entry may match decode sources
- fwd_stall  output  1  matched entry's data not yet available
- fwd_wb_reg  output  5  destination for comparison
- fwd_data  output  XLEN  forwarded value

Behaviour:
- Reset: one clock `clk`; reset is asynchronous and active-low on `reset_n`. While reset_n=0:
  - state=EMPTY
  - all outputs 0, except in_ready=0 (reset holds the stage closed)
  - held wb_reg, wb_en and data=0
- States and transitions:
  - EMPTY: in_valid&in_ready -> READY if in_result_valid (capture in_result), else PENDING. Captures in_wb_en and in_wb_reg.
  - PENDING: rsp_valid -> READY (capture rsp_data).
  - PENDING with flush: -> DRAIN if !rsp_valid; -> EMPTY if rsp_valid in the same cycle.
  - READY: out_ready -> EMPTY, or directly reload (-> READY/PENDING) if a new instruction is accepted the same cycle. flush -> EMPTY.
  - DRAIN: absorbs the orphaned response. rsp_valid -> EMPTY.
- Handshake:
  - in_ready = !flush & (EMPTY | (READY & out_ready)). In-flight responses must never be lost, so PENDING and DRAIN never accept.
  - out_valid = (state==READY). out_* come straight from registers.
  - An instruction leaves the stage only on out_valid&out_ready. flush in READY drops the entry without asserting a transfer.
- Forwarding outputs:
  - fwd_valid = (PENDING|READY) & held wb_en. DRAIN and EMPTY give 0.
  - fwd_wb_reg = held wb_reg; it is meaningful only when fwd_valid=1. The stage does not mask x0; the consumer does.
  - fwd_stall = PENDING & !(FWD_RSP_BYPASS & rsp_valid).
  - fwd_data = rsp_data when PENDING & rsp_valid & FWD_RSP_BYPASS; otherwise the held data.
- Simultaneous events:
  - flush beats in_valid; nothing is accepted.
  - flush beats out_ready in READY; out_valid is still 1 that cycle, but the consumer must also honour flush.
- rsp_valid in EMPTY or READY is a protocol violation: it is ignored and the state is unchanged. Carries a simulation assertion.
- Reset mid-PENDING/DRAIN returns to EMPTY. The response source is reset by the same reset_n.
- No combinational path from out_ready to out_*. The only combinational path is out_ready -> in_ready.
- Expected size: 150-250 lines.

Test Plan:
- ALU entry: in_valid=1, in_result_valid=1, wb_reg=5, result=0x1234, out_ready=0 -> next cycle: fwd_valid=1, fwd_stall=0, fwd_wb_reg=5, fwd_data=0x1234, out_valid=1, in_ready=0. Then out_ready=1 -> EMPTY, fwd_valid=0.
- Load entry: in_result_valid=0, wb_reg=7 -> fwd_stall=1 for 3 cycles. rsp_valid=1, rsp_data=0xDEADBEEF -> same cycle fwd_stall=0, fwd_data=0xDEADBEEF (bypass). Next cycle out_valid=1, out_data=0xDEADBEEF.
- Back-to-back: READY with out_ready=1 and in_valid=1 (wb_reg=3, result=9) -> in_ready=1, and the next cycle holds wb_reg=3 with no bubble.
- Flush while PENDING with no response -> DRAIN: fwd_valid=0, in_ready=0. rsp_valid the following cycle -> EMPTY; that data never appears on out_data.
- Flush and rsp_valid in the same PENDING cycle -> EMPTY directly. Also: flush and in_valid in the same EMPTY cycle -> nothing captured, fwd_valid stays 0.
- in_wb_en=0 entry -> fwd_valid=0 throughout while out_valid still cycles normally. Assert reset_n=0 mid-PENDING -> all outputs 0 immediately.
